ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_CYCLES, default 8: consecutive identical synchronized ps2_clk samples required before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 10000: clk cycles allowed between sample events inside a frame; only used when PS2_RX_TIMEOUT_EN is defined.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  PS/2 clock from device, idle high, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 data from device, idle high, asynchronous to clk.
REQ-007 data  output  8  last correctly received byte.
REQ-008 valid  output  1  one-cycle pulse when data updates.
REQ-009 parity_err  output  1  one-cycle pulse on odd-parity failure.
REQ-010 frame_err  output  1  one-cycle pulse on bad stop bit or timeout.
REQ-011 busy  output  1  high while a frame is in progress.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-013 Filtered clock SHALL change state only after FILTER_CYCLES consecutive synchronized samples differing from its current value; shorter pulses are ignored.
REQ-014 A sample event SHALL occur in the cycle the filtered clock goes 1->0; synchronized ps2_data is captured in that cycle.
REQ-015 Frame: start(0), 8 data bits LSB first, odd parity, stop(1); 11 sample events.
REQ-016 States IDLE, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-017 IDLE: sample of 0 -> DATA with bit count 0; sample of 1 ignored, state stays IDLE.
REQ-018 DATA: each sample shifts into an 8-bit register; after the 8th -> PARITY.
REQ-019 PARITY: sample stored -> STOP.
REQ-020 STOP: on sample, return to IDLE and evaluate: stop=1 and parity OK -> data updated, valid pulse; parity bad -> parity_err pulse; stop=0 -> frame_err pulse; both bad -> both error pulses.
REQ-021 valid and the error outputs SHALL be mutually exclusive; on any error data holds its previous value.
REQ-022 Output pulses SHALL assert the cycle after the stop-bit sample event, i.e. FILTER_CYCLES+3 clk cycles after the ps2_clk pin falls, lasting exactly one cycle.
REQ-023 Parity check: valid when XOR of 8 data bits and parity bit equals 1.
REQ-024 Back-to-back frames SHALL be accepted with no gap beyond the idle-high stop period.

Reset
REQ-025 While reset is high: state IDLE, data=0x00, valid=0, parity_err=0, frame_err=0, busy=0, bit count 0.
REQ-026 Synchronizer flops and filtered clock SHALL reset to 1; filter counter and timeout counter to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame with no pulse on any output.

Configuration
REQ-028 Macro PS2_RX_TIMEOUT_EN defined: a counter clears on each sample event and increments while busy; reaching TIMEOUT_CYCLES SHALL pulse frame_err for one cycle and return to IDLE, discarding the partial frame.
REQ-029 Macro PS2_RX_TIMEOUT_EN undefined: no timeout counter exists; a stalled frame holds busy high indefinitely until reset or further clock edges.

Verification
REQ-030 Frame 0xA5, parity 1, stop 1, bit period 4000 clk, clock low in second half -> data=0xA5, valid one-cycle pulse, no error pulses.
REQ-031 Frame 0x00 with parity bit 0 -> parity_err pulse, valid stays 0, data remains 0xA5.
REQ-032 Frame 0xFF, parity 1, stop 0 -> frame_err pulse, valid 0, busy 0 afterwards.
REQ-033 In IDLE with ps2_data=0, ps2_clk low pulse of FILTER_CYCLES-1 clk cycles -> busy stays 0, no pulses.
REQ-034 Start bit plus 3 data bits, then clock stops -> with PS2_RX_TIMEOUT_EN: frame_err pulse TIMEOUT_CYCLES after last sample, busy 0; without it: busy remains 1.
REQ-035 Reset asserted after 5 bits of a frame -> all outputs 0, no pulse; next complete frame 0x3C -> data=0x3C, valid pulse.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// ps2_clk and ps2_data are synchronized and the clock is glitch filtered.
// Each falling edge of the filtered clock samples one bit of an 11-bit frame:
// start, 8 data bits LSB first, odd parity, stop.
// Optional feature: define PS2_RX_TIMEOUT_EN to abandon frames whose clock
// stalls for TIMEOUT_CYCLES clk cycles between sample events.
module ps2_rx #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]     clk_sync_q, clk_sync_d;
    logic [1:0]     dat_sync_q, dat_sync_d;
    logic           filt_q, filt_d;
    logic           filt_prev_q;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           ps2_clk_s, ps2_dat_s;
    logic           sample_evt;
    logic           parity_ok;

    state_t         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [7:0]     data_q;
    logic           valid_q, parity_err_q, frame_err_q;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmo_q;
`endif

    assign ps2_clk_s = clk_sync_q[1];
    assign ps2_dat_s = dat_sync_q[1];

    // Synchronizer shift and clock filter next-state: the filtered clock
    // flips only after FILTER_CYCLES consecutive disagreeing samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        fcnt_d     = '0;
        if (ps2_clk_s != filt_q) begin
            if (fcnt_q == FCW'(FILTER_CYCLES - 1)) begin
                filt_d = ps2_clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, filter and edge-detect registers; idle line is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
        end
    end

    // Sample in the cycle the registered filtered clock shows a 1->0 step.
    assign sample_evt = filt_prev_q & ~filt_q;
    assign parity_ok  = ^{shift_q, par_q};

    // Frame FSM with registered data and single-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (sample_evt) begin
`ifdef PS2_RX_TIMEOUT_EN
                tmo_q <= '0;
`endif
                case (state_q)
                    IDLE: begin
                        if (!ps2_dat_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {ps2_dat_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= ps2_dat_s;
                        state_q <= STOP;
                    end
                    default: begin
                        state_q      <= IDLE;
                        parity_err_q <= ~parity_ok;
                        frame_err_q  <= ~ps2_dat_s;
                        if (parity_ok && ps2_dat_s) begin
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
                        end
                    end
                endcase
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (state_q == IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_q       <= '0;
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: stimulus pushes expected pulses, a monitor
// pops and compares whenever valid/parity_err/frame_err is seen.
module tb_ps2_rx;
    localparam int F = 8;
    localparam int T = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid, parity_err, frame_err, busy;

    ps2_rx #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .valid(valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags = {valid, parity_err, frame_err}
    typedef struct {
        logic [2:0] flags;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   last_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic push(input logic [2:0] flags, input logic [7:0] d, input int lat);
        exp_t e;
        e.flags = flags;
        e.data  = d;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    // Drive n bits; data changes while the clock is high, clock low in 2nd half.
    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(half);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            tick(half);
            ps2_clk = 1'b1;
        end
    endtask

    // Monitor: one comparison set per observed pulse, plus pulse-width check.
    logic prev_any = 1'b0;
    always @(negedge clk) begin
        logic [2:0] obs;
        exp_t       e;
        if (rst) begin
            prev_any = 1'b0;
        end else begin
            obs = {valid, parity_err, frame_err};
            if (obs != 3'b000) begin
                if (prev_any) begin
                    check("pulse_len_cycles", 2, 1);
                end else if (sb.size() == 0) begin
                    check("unexpected_pulse_flags", {29'd0, obs}, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_flags", {29'd0, obs}, {29'd0, e.flags});
                    check("pulse_data", {24'd0, data}, {24'd0, e.data});
                    check("pulse_latency", cyc - last_fall, e.lat);
                end
            end
            prev_any = (obs != 3'b000);
        end
    end

    initial begin
        tick(5);
        check("rst_data", {24'd0, data}, 0);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_parity_err", {31'd0, parity_err}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        tick(5);

        // 0xA5, good parity and stop, slow bit period
        push(3'b100, 8'hA5, F + 3);
        send_bits(frame(8'hA5, 1'b1, 1'b1), 11, 2000);
        tick(50);
        check("data_after_A5", {24'd0, data}, 32'hA5);

        // 0x00 with parity 0 -> parity error, data held
        push(3'b010, 8'hA5, F + 3);
        send_bits(frame(8'h00, 1'b0, 1'b1), 11, 100);
        tick(50);

        // 0xFF, parity ok, stop 0 -> frame error
        push(3'b001, 8'hA5, F + 3);
        send_bits(frame(8'hFF, 1'b1, 1'b0), 11, 100);
        tick(50);
        check("busy_after_frame_err", {31'd0, busy}, 0);

        // both parity and stop bad
        push(3'b011, 8'hA5, F + 3);
        send_bits(frame(8'h00, 1'b0, 1'b0), 11, 100);
        tick(50);

        // back-to-back frames
        push(3'b100, 8'h81, F + 3);
        push(3'b100, 8'h7E, F + 3);
        send_bits(frame(8'h81, 1'b1, 1'b1), 11, 100);
        send_bits(frame(8'h7E, 1'b1, 1'b1), 11, 100);
        tick(50);
        check("data_after_b2b", {24'd0, data}, 32'h7E);

        // short clock glitch with data low must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(F - 1);
        ps2_clk = 1'b1;
        tick(50);
        check("busy_after_glitch", {31'd0, busy}, 0);
        ps2_data = 1'b1;
        tick(10);

        // start + 3 data bits, then clock stalls
        send_bits(frame(8'h55, 1'b1, 1'b1), 4, 100);
        ps2_data = 1'b1;
        tick(20);
        check("busy_mid_frame", {31'd0, busy}, 1);
`ifdef PS2_RX_TIMEOUT_EN
        push(3'b001, 8'h7E, F + 3 + T);
        tick(T + 50);
        check("busy_after_timeout", {31'd0, busy}, 0);
`else
        tick(T + 50);
        check("busy_stalled", {31'd0, busy}, 1);
`endif

        // reset in the middle of a frame
        send_bits(frame(8'h3C, 1'b1, 1'b1), 5, 100);
        rst      = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        check("midrst_data", {24'd0, data}, 0);
        check("midrst_valid", {31'd0, valid}, 0);
        check("midrst_parity_err", {31'd0, parity_err}, 0);
        check("midrst_frame_err", {31'd0, frame_err}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        tick(20);
        push(3'b100, 8'h3C, F + 3);
        send_bits(frame(8'h3C, 1'b1, 1'b1), 11, 100);
        tick(50);
        check("data_after_3C", {24'd0, data}, 32'h3C);

        tick(20);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
